// File: rtl/cpu_pkg.sv
// Shared CPU decode definitions.
// - imm_sel_e : immediate format select encodings.
// - IMM*_W    : widths of the immediate fields carried in the instruction payload.
package cpu_pkg;

  typedef enum logic [1:0] {
    IMM_I17 = 2'b00,
    IMM_I22 = 2'b01,
    IMM_Z17 = 2'b10,
    IMM_J26 = 2'b11
  } imm_sel_e;

  localparam int unsigned IMM17_W = 17;
  localparam int unsigned IMM22_W = 22;
  localparam int unsigned IMM26_W = 26;

endpackage : cpu_pkg

// File: rtl/sign_extend.sv
// Widens an IN_W-bit field to OUT_W bits.
// - SIGNED=1 : replicate the field MSB into the upper bits.
// - SIGNED=0 : fill the upper bits with zero.
// Ports:
//   din  in  IN_W   field to extend
//   dout out OUT_W  extended value
module sign_extend #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 32,
  parameter bit          SIGNED = 1'b1
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  if (SIGNED) begin : g_sext
    assign dout = {{(OUT_W-IN_W){din[IN_W-1]}}, din};
  end else begin : g_zext
    assign dout = {{(OUT_W-IN_W){1'b0}}, din};
  end

endmodule : sign_extend

// File: rtl/imm_extender.sv
// Decode-stage immediate generator.
// Selects a 17-, 22- or 26-bit field from the instruction payload and extends
// it to XLEN bits. imm_out is combinational (feeds ALU operand muxes and
// target adders in the same cycle); imm_out_q is its registered copy for the
// next pipeline stage.
// Ports:
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous active-high reset (clears imm_out_q)
//   en        in   1       pipeline advance; 0 holds imm_out_q
//   imm_sel   in   2       format select (cpu_pkg::imm_sel_e)
//   inst      in   INST_W  instruction payload, opcode stripped
//   imm_out   out  XLEN    combinational extended immediate
//   imm_out_q out  XLEN    imm_out registered one cycle
module imm_extender
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned INST_W = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        imm_sel,
  input  logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   imm_out,
  output logic [XLEN-1:0]   imm_out_q
);

  logic [XLEN-1:0] i17_ext;
  logic [XLEN-1:0] i22_ext;
  logic [XLEN-1:0] z17_ext;
  logic [XLEN-1:0] j26_ext;
  logic [XLEN-1:0] imm_out_d;
  imm_sel_e        sel;

  // inst[26] belongs to no format; tie it off explicitly.
  logic unused_inst_msb;
  assign unused_inst_msb = inst[INST_W-1];

  assign sel = imm_sel_e'(imm_sel);

  sign_extend #(.IN_W(IMM17_W), .OUT_W(XLEN), .SIGNED(1'b1)) u_i17 (
    .din  (inst[IMM17_W-1:0]),
    .dout (i17_ext)
  );

  sign_extend #(.IN_W(IMM22_W), .OUT_W(XLEN), .SIGNED(1'b1)) u_i22 (
    .din  (inst[IMM22_W-1:0]),
    .dout (i22_ext)
  );

  sign_extend #(.IN_W(IMM17_W), .OUT_W(XLEN), .SIGNED(1'b0)) u_z17 (
    .din  (inst[IMM17_W-1:0]),
    .dout (z17_ext)
  );

  sign_extend #(.IN_W(IMM26_W), .OUT_W(XLEN), .SIGNED(1'b1)) u_j26 (
    .din  (inst[IMM26_W-1:0]),
    .dout (j26_ext)
  );

  always_comb begin
    imm_out = '0;
    unique case (sel)
      IMM_I17: imm_out = i17_ext;
      IMM_I22: imm_out = i22_ext;
      IMM_Z17: imm_out = z17_ext;
      IMM_J26: imm_out = j26_ext;
    endcase
  end

  always_comb begin
    imm_out_d = en ? imm_out : imm_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imm_out_q <= '0;
    end else begin
      imm_out_q <= imm_out_d;
    end
  end

endmodule : imm_extender

// File: tb/tb_imm_extender.sv
// Scoreboard bench for imm_extender. The driver applies one directed vector
// per clock shortly after the rising edge and queues the hand-computed
// imm_out and imm_out_q expected for that cycle; the monitor pops and checks
// one entry on every falling edge.
module tb_imm_extender;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  imm_sel;
  logic [26:0] inst;
  logic [31:0] imm_out;
  logic [31:0] imm_out_q;

  imm_extender #(.XLEN(32), .INST_W(27)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .imm_sel   (imm_sel),
    .inst      (inst),
    .imm_out   (imm_out),
    .imm_out_q (imm_out_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  sel;
    logic [26:0] inst;
    logic [31:0] exp_out;
    logic [31:0] exp_q;   // imm_out_q expected in the cycle this vector is applied
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] exp_out;
    logic [31:0] exp_q;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic r, input logic e, input logic [1:0] s,
                              input logic [26:0] i, input logic [31:0] eo,
                              input logic [31:0] eq);
    vec_t v;
    v.rst = r; v.en = e; v.sel = s; v.inst = i; v.exp_out = eo; v.exp_q = eq;
    vecs.push_back(v);
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        total++;
        if (imm_out !== x.exp_out) begin
          bad++;
          $display("FAIL imm_out vec%0d: got %h expected %h", x.idx, imm_out, x.exp_out);
        end
        total++;
        if (imm_out_q !== x.exp_q) begin
          bad++;
          $display("FAIL imm_out_q vec%0d: got %h expected %h", x.idx, imm_out_q, x.exp_q);
        end
      end
    end
  end

  // Driver
  initial begin
    //   rst   en    sel    inst          imm_out       imm_out_q
    add(1'b0, 1'b0, 2'b00, 27'h0010000, 32'hFFFF0000, 32'h00000000); // 0  I17 neg, reset value
    add(1'b0, 1'b0, 2'b00, 27'h0008000, 32'h00008000, 32'h00000000); // 1  I17 pos
    add(1'b0, 1'b0, 2'b00, 27'h7FE0000, 32'h00000000, 32'h00000000); // 2  I17 masking
    add(1'b0, 1'b0, 2'b01, 27'h0200000, 32'hFFE00000, 32'h00000000); // 3  I22 neg
    add(1'b0, 1'b0, 2'b01, 27'h0100000, 32'h00100000, 32'h00000000); // 4  I22 pos
    add(1'b0, 1'b0, 2'b11, 27'h2000000, 32'hFE000000, 32'h00000000); // 5  J26 neg
    add(1'b0, 1'b0, 2'b11, 27'h1000000, 32'h01000000, 32'h00000000); // 6  J26 pos
    add(1'b0, 1'b0, 2'b11, 27'h4000000, 32'h00000000, 32'h00000000); // 7  J26 masking
    add(1'b0, 1'b0, 2'b10, 27'h001FFFF, 32'h0001FFFF, 32'h00000000); // 8  Z17
    add(1'b0, 1'b0, 2'b00, 27'h001FFFF, 32'hFFFFFFFF, 32'h00000000); // 9  same bits as I17
    add(1'b0, 1'b1, 2'b01, 27'h0200000, 32'hFFE00000, 32'h00000000); // 10 load FFE00000
    add(1'b0, 1'b0, 2'b00, 27'h0008000, 32'h00008000, 32'hFFE00000); // 11 stall
    add(1'b0, 1'b0, 2'b00, 27'h0010000, 32'hFFFF0000, 32'hFFE00000); // 12 stall
    add(1'b0, 1'b0, 2'b10, 27'h0010000, 32'h00010000, 32'hFFE00000); // 13 sel change only
    add(1'b0, 1'b1, 2'b10, 27'h0010000, 32'h00010000, 32'hFFE00000); // 14 load 00010000
    add(1'b1, 1'b1, 2'b11, 27'h2000000, 32'hFE000000, 32'h00010000); // 15 rst beats en
    add(1'b0, 1'b0, 2'b11, 27'h2000000, 32'hFE000000, 32'h00000000); // 16
    add(1'b0, 1'b1, 2'b11, 27'h1000000, 32'h01000000, 32'h00000000); // 17 load 01000000
    add(1'b1, 1'b0, 2'b01, 27'h0100000, 32'h00100000, 32'h01000000); // 18 rst with en=0
    add(1'b0, 1'b0, 2'b01, 27'h0100000, 32'h00100000, 32'h00000000); // 19

    rst = 1'b1; en = 1'b0; imm_sel = 2'b00; inst = '0;
    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t x;
      #2;
      rst = vecs[i].rst; en = vecs[i].en; imm_sel = vecs[i].sel; inst = vecs[i].inst;
      x.idx = i; x.exp_out = vecs[i].exp_out; x.exp_q = vecs[i].exp_q;
      sb.push_back(x);
      @(posedge clk);
    end
    rst = 1'b0; en = 1'b0;

    for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_imm_extender
